// File: rtl/sgpr_rd_port_arbiter_if.sv
// Purpose: bundles the client-side request/return signals and the SGPR bank
//          read-port signals of the read arbiter.
// Ports:
//   port_rd_req/port_rd_addr  client requests and packed addresses
//   port_rd_gnt               one-hot grant back to the clients
//   port_rd_valid/port_rd_data  tagged return data (data broadcast)
//   rd_en/rd_addr/rd_data     SGPR bank read port
// Modports: slave = arbiter view, master = client/bank side view.
interface sgpr_rd_port_arbiter_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 128
);
    logic [NUM_PORTS-1:0]        port_rd_req;
    logic [NUM_PORTS*ADDR_W-1:0] port_rd_addr;
    logic [NUM_PORTS-1:0]        port_rd_gnt;
    logic [NUM_PORTS-1:0]        port_rd_valid;
    logic [DATA_W-1:0]           port_rd_data;
    logic                        rd_en;
    logic [ADDR_W-1:0]           rd_addr;
    logic [DATA_W-1:0]           rd_data;

    modport slave (
        input  port_rd_req, port_rd_addr, rd_data,
        output port_rd_gnt, port_rd_valid, port_rd_data, rd_en, rd_addr
    );

    modport master (
        output port_rd_req, port_rd_addr, rd_data,
        input  port_rd_gnt, port_rd_valid, port_rd_data, rd_en, rd_addr
    );
endinterface

// File: rtl/sgpr_rd_port_arbiter.sv
// Purpose: round-robin N:1 arbiter in front of a single SGPR bank read port.
//          One grant per cycle; the granted one-hot vector rides a RD_LAT-deep
//          pipeline so returned bank data is tagged with its requester.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    sgpr_rd_port_arbiter_if.slave (client request/grant/return + bank port)
// Note: grant, rd_en and rd_addr are combinational from the requests so the
//       bank sees the address in the grant cycle; port_rd_valid is registered.
module sgpr_rd_port_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sgpr_rd_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] req_eff;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     cand [NUM_PORTS];
    logic [PTR_W-1:0]     winner;
    logic                 found;
    logic [NUM_PORTS-1:0] gnt;
    logic [ADDR_W-1:0]    addr_sel;
    logic [NUM_PORTS-1:0] stage [RD_LAT];

    // Nothing may be granted while reset is asserted.
    assign req_eff = rst_n ? bus.port_rd_req : '0;

    // Scan order: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_PORTS.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = PTR_W'((32'(rr_ptr) + 32'(i)) % NUM_PORTS);
        end
    end

    // First requester in scan order wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_eff[cand[i]]) begin
                found  = 1'b1;
                winner = cand[i];
            end
        end
    end

    // One-hot grant and winner address mux; address is zero when idle.
    always_comb begin
        gnt      = '0;
        addr_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (found && (winner == PTR_W'(i))) begin
                gnt[i]   = 1'b1;
                addr_sel = bus.port_rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign bus.port_rd_gnt = gnt;
    assign bus.rd_en       = found;
    assign bus.rd_addr     = addr_sel;

    // Pointer moves past the winner; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            if (32'(winner) == (NUM_PORTS - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= winner + PTR_W'(1);
            end
        end
    end

    // Return tag pipeline, aligned to the bank read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign bus.port_rd_valid = stage[RD_LAT-1];
    assign bus.port_rd_data  = bus.rd_data;

    // Pointer can only leave the legal range through a logic fault.
    rr_ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(rr_ptr) < NUM_PORTS);

endmodule
